// File: rtl/branch_target_predictor_if.sv
// Fetch/resolve bus of the branch target predictor.
// Fetch lookup, resolver writeback and performance counters.
interface branch_target_predictor_if #(
    parameter int XLEN   = 64,
    parameter int STAT_W = 32
);
    logic [XLEN-1:0]   pc_f;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [XLEN-1:0]   upd_pred_target;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output pc_f, upd_valid, upd_pc, upd_is_jump, upd_taken,
        output upd_target, upd_pred_taken, upd_pred_target, stat_clr,
        input  pred_taken, pred_target, mispredict, redirect_pc,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  pc_f, upd_valid, upd_pc, upd_is_jump, upd_taken,
        input  upd_target, upd_pred_taken, upd_pred_target, stat_clr,
        output pred_taken, pred_target, mispredict, redirect_pc,
        output stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters.
// Same-cycle fetch prediction, resolver writeback, stats.
module branch_target_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 32
) (
    input logic clk,
    input logic reset,
    branch_target_predictor_if.slave bus
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_W    = XLEN - IDX_BITS - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic             jmp_q    [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [STAT_W-1:0] br_q;
    logic [STAT_W-1:0] mp_q;

    logic [IDX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]    tag_f;
    logic                hit_f;
    logic [IDX_BITS-1:0] idx_u;
    logic [TAG_W-1:0]    tag_u;
    logic                hit_u;
    logic                mispredict;
    logic                unused_pc_bits;

    assign idx_f = bus.pc_f[IDX_BITS+1:2];
    assign tag_f = bus.pc_f[XLEN-1:IDX_BITS+2];
    assign idx_u = bus.upd_pc[IDX_BITS+1:2];
    assign tag_u = bus.upd_pc[XLEN-1:IDX_BITS+2];

    // Instructions are word aligned; the byte offset never selects an entry.
    assign unused_pc_bits = ^{bus.pc_f[1:0], bus.upd_pc[1:0]};

    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

    assign bus.pred_taken  = hit_f && (jmp_q[idx_f] || ctr_q[idx_f][1]);
    assign bus.pred_target = bus.pred_taken ? target_q[idx_f]
                                            : bus.pc_f + XLEN'(4);

    assign mispredict = bus.upd_valid &&
        ((bus.upd_taken != bus.upd_pred_taken) ||
         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

    assign bus.mispredict  = mispredict;
    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target
                                           : bus.upd_pc + XLEN'(4);

    assign bus.stat_branches    = br_q;
    assign bus.stat_mispredicts = mp_q;

    // Table write: train on hits, allocate only taken misses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                jmp_q[i]    <= 1'b0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (bus.upd_valid) begin
            if (hit_u) begin
                if (bus.upd_taken) begin
                    if (ctr_q[idx_u] != 2'b11)
                        ctr_q[idx_u] <= ctr_q[idx_u] + 2'd1;
                    target_q[idx_u] <= bus.upd_target;
                    jmp_q[idx_u]    <= bus.upd_is_jump;
                end else if (ctr_q[idx_u] != 2'b00) begin
                    ctr_q[idx_u] <= ctr_q[idx_u] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                valid_q[idx_u]  <= 1'b1;
                tag_q[idx_u]    <= tag_u;
                target_q[idx_u] <= bus.upd_target;
                jmp_q[idx_u]    <= bus.upd_is_jump;
                ctr_q[idx_u]    <= 2'b10;
            end
        end
    end

    // Performance counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (bus.stat_clr) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            if (bus.upd_valid)
                br_q <= br_q + STAT_W'(1);
            if (mispredict)
                mp_q <= mp_q + STAT_W'(1);
        end
    end
endmodule
